color_blob_tracker: RTL and testbench

- Downstream consumer of the color_threshold per-pixel match stream.
- Tracks raster position and, per frame, accumulates matched-pixel count, coordinate sums and bounding box.
- Publishes the frame's results at the next start-of-frame so the game logic can derive the tracked object's centroid and extent.
- Sits between color_threshold's stream output and the game's AXI4-Lite status register file.

---
 rtl/color_blob_pkg.sv | 14 +
 rtl/blob_raster_counter.sv | 42 ++++
 rtl/color_blob_tracker.sv | 167 ++++++++++++++++
 tb/tb_color_blob_tracker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_blob_pkg.sv
// Shared widths and FSM encoding for the colour-blob tracker.
package color_blob_pkg;

  localparam int unsigned X_W_DEF   = 10;
  localparam int unsigned Y_W_DEF   = 10;
  localparam int unsigned CNT_W_DEF = 20;
  localparam int unsigned SUM_W_DEF = 30;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/blob_raster_counter.sv
// Raster x/y position of the current beat, with saturation and a sticky overrun flag.
module blob_raster_counter #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           step,
  input  logic           sof,
  input  logic           eol,
  output logic [X_W-1:0] x_c,
  output logic [Y_W-1:0] y_c,
  output logic           overrun
);

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  // A start-of-frame beat is always pixel (0,0), whatever the counters held.
  assign x_c = sof ? '0 : x_q;
  assign y_c = sof ? '0 : y_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      overrun <= 1'b0;
    end else if (step) begin
      x_q <= x_c;
      y_q <= y_c;
      if (eol) begin
        x_q <= '0;
        if (&y_c) overrun <= 1'b1;
        else      y_q     <= y_c + Y_W'(1);
      end else begin
        if (&x_c) overrun <= 1'b1;
        else      x_q     <= x_c + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/color_blob_tracker.sv
// Per-frame matched-pixel statistics (count, coordinate sums, bounding box),
// published on the next start-of-frame.
module color_blob_tracker
  import color_blob_pkg::*;
#(
  parameter int unsigned X_W   = X_W_DEF,
  parameter int unsigned Y_W   = Y_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             enable,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tdata,
  output logic             frame_done,
  output logic [CNT_W-1:0] blob_count,
  output logic [SUM_W-1:0] sum_x,
  output logic [SUM_W-1:0] sum_y,
  output logic [X_W-1:0]   min_x,
  output logic [X_W-1:0]   max_x,
  output logic [Y_W-1:0]   min_y,
  output logic [Y_W-1:0]   max_y,
  output logic             blob_valid,
  output logic             err_overrun
);

  state_e state_q, state_d;
  logic   ready_q;
  logic   beat, start, step, publish;

  logic [X_W-1:0]   px_x;
  logic [Y_W-1:0]   px_y;

  logic [CNT_W-1:0] acc_cnt, cnt_base, cnt_next;
  logic [SUM_W-1:0] acc_sx, acc_sy, sx_base, sy_base, sx_next, sy_next;
  logic [SUM_W:0]   sx_add, sy_add;
  logic [X_W-1:0]   acc_mnx, acc_mxx, mnx_base, mxx_base, mnx_next, mxx_next;
  logic [Y_W-1:0]   acc_mny, acc_mxy, mny_base, mxy_base, mny_next, mxy_next;

  assign s_axis_tready = ready_q;
  assign beat          = s_axis_tvalid & ready_q;

  blob_raster_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_raster (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .step    (step),
    .sof     (start),
    .eol     (s_axis_tlast),
    .x_c     (px_x),
    .y_c     (px_y),
    .overrun (err_overrun)
  );

  // Frame FSM: start/step/publish strobes for the current cycle.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    publish = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat && s_axis_tuser && enable) begin
          state_d = ACCUM;
          start   = 1'b1;
          step    = 1'b1;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (beat) begin
          step = 1'b1;
          if (s_axis_tuser) begin
            start   = 1'b1;
            publish = 1'b1;
          end
        end
      end
    endcase
  end

  // Next accumulator values: restart from init on SOF, then fold in this pixel.
  always_comb begin
    cnt_base = start ? '0 : acc_cnt;
    sx_base  = start ? '0 : acc_sx;
    sy_base  = start ? '0 : acc_sy;
    mnx_base = start ? '1 : acc_mnx;
    mxx_base = start ? '0 : acc_mxx;
    mny_base = start ? '1 : acc_mny;
    mxy_base = start ? '0 : acc_mxy;

    sx_add = {1'b0, sx_base} + (SUM_W+1)'(px_x);
    sy_add = {1'b0, sy_base} + (SUM_W+1)'(px_y);

    cnt_next = cnt_base;
    sx_next  = sx_base;
    sy_next  = sy_base;
    mnx_next = mnx_base;
    mxx_next = mxx_base;
    mny_next = mny_base;
    mxy_next = mxy_base;
    if (s_axis_tdata) begin
      cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
      sx_next  = sx_add[SUM_W] ? '1 : sx_add[SUM_W-1:0];
      sy_next  = sy_add[SUM_W] ? '1 : sy_add[SUM_W-1:0];
      mnx_next = (px_x < mnx_base) ? px_x : mnx_base;
      mxx_next = (px_x > mxx_base) ? px_x : mxx_base;
      mny_next = (px_y < mny_base) ? px_y : mny_base;
      mxy_next = (px_y > mxy_base) ? px_y : mxy_base;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      frame_done <= 1'b0;
      acc_cnt    <= '0;
      acc_sx     <= '0;
      acc_sy     <= '0;
      acc_mnx    <= '1;
      acc_mxx    <= '0;
      acc_mny    <= '1;
      acc_mxy    <= '0;
      blob_count <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      min_x      <= '0;
      max_x      <= '0;
      min_y      <= '0;
      max_y      <= '0;
      blob_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= 1'b1;
      frame_done <= publish;
      if (step) begin
        acc_cnt <= cnt_next;
        acc_sx  <= sx_next;
        acc_sy  <= sy_next;
        acc_mnx <= mnx_next;
        acc_mxx <= mxx_next;
        acc_mny <= mny_next;
        acc_mxy <= mxy_next;
      end
      // An empty frame publishes a zero bounding box rather than the init sentinels.
      if (publish) begin
        blob_count <= acc_cnt;
        sum_x      <= acc_sx;
        sum_y      <= acc_sy;
        blob_valid <= |acc_cnt;
        min_x      <= (|acc_cnt) ? acc_mnx : '0;
        max_x      <= (|acc_cnt) ? acc_mxx : '0;
        min_y      <= (|acc_cnt) ? acc_mny : '0;
        max_y      <= (|acc_cnt) ? acc_mxy : '0;
      end
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Scoreboard bench: a pixel-list reference model predicts each published frame,
// monitors compare whenever a tracker raises frame_done.
module tb_color_blob_tracker;

  localparam int unsigned BX = 10, BY = 10, BC = 20, BS = 30;
  localparam int unsigned SX = 3,  SY = 3,  SC = 4,  SS = 7;

  typedef struct {
    longint cnt, sx, sy, mnx, mxx, mny, mxy;
    bit     bv, err;
    longint cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  longint cyc = 0;
  int n_tests = 0, n_fail = 0;

  // Instance 0: default widths
  logic en0, v0, u0, l0, d0, rdy0, fd0, bv0, err0;
  logic [BC-1:0] cnt0;
  logic [BS-1:0] sx0, sy0;
  logic [BX-1:0] mnx0, mxx0;
  logic [BY-1:0] mny0, mxy0;

  // Instance 1: 3-bit coordinates for saturation cases
  logic en1, v1, u1, l1, d1, rdy1, fd1, bv1, err1;
  logic [SC-1:0] cnt1;
  logic [SS-1:0] sx1, sy1;
  logic [SX-1:0] mnx1, mxx1;
  logic [SY-1:0] mny1, mxy1;

  color_blob_tracker u_big (
    .ACLK(clk), .ARESETN(rst_n), .enable(en0), .s_axis_tvalid(v0), .s_axis_tready(rdy0),
    .s_axis_tuser(u0), .s_axis_tlast(l0), .s_axis_tdata(d0), .frame_done(fd0),
    .blob_count(cnt0), .sum_x(sx0), .sum_y(sy0), .min_x(mnx0), .max_x(mxx0),
    .min_y(mny0), .max_y(mxy0), .blob_valid(bv0), .err_overrun(err0));

  color_blob_tracker #(.X_W(SX), .Y_W(SY), .CNT_W(SC), .SUM_W(SS)) u_small (
    .ACLK(clk), .ARESETN(rst_n), .enable(en1), .s_axis_tvalid(v1), .s_axis_tready(rdy1),
    .s_axis_tuser(u1), .s_axis_tlast(l1), .s_axis_tdata(d1), .frame_done(fd1),
    .blob_count(cnt1), .sum_x(sx1), .sum_y(sy1), .min_x(mnx1), .max_x(mxx1),
    .min_y(mny1), .max_y(mxy1), .blob_valid(bv1), .err_overrun(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: frame in progress, raster position, matched pixel list.
  bit     m_acc[2];
  bit     m_err[2];
  longint m_x[2], m_y[2];
  longint xmax[2], ymax[2], cmax[2], smax[2];
  longint px_x[2][$];
  longint px_y[2][$];
  res_t   q0[$], q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t summarize(input int id);
    res_t r;
    longint n, sxs, sys;
    n = px_x[id].size();
    sxs = 0; sys = 0;
    r.mnx = 0; r.mxx = 0; r.mny = 0; r.mxy = 0;
    for (int i = 0; i < n; i++) begin
      sxs += px_x[id][i];
      sys += px_y[id][i];
      if (i == 0 || px_x[id][i] < r.mnx) r.mnx = px_x[id][i];
      if (i == 0 || px_x[id][i] > r.mxx) r.mxx = px_x[id][i];
      if (i == 0 || px_y[id][i] < r.mny) r.mny = px_y[id][i];
      if (i == 0 || px_y[id][i] > r.mxy) r.mxy = px_y[id][i];
    end
    r.cnt = (n > cmax[id]) ? cmax[id] : n;
    r.sx  = (sxs > smax[id]) ? smax[id] : sxs;
    r.sy  = (sys > smax[id]) ? smax[id] : sys;
    r.bv  = (n != 0);
    r.err = 1'b0;
    r.cyc = 0;
    return r;
  endfunction

  task automatic model_step(input int id, input bit v, input bit u, input bit l,
                            input bit d, input bit e, input longint at_cyc);
    res_t r;
    bit   pub;
    pub = 1'b0;
    if (!e) begin
      m_acc[id] = 1'b0;
      return;
    end
    if (!v) return;
    if (!m_acc[id]) begin
      if (!u) return;
      m_acc[id] = 1'b1;
    end else if (u) begin
      r   = summarize(id);
      pub = 1'b1;
    end
    if (u) begin
      m_x[id] = 0;
      m_y[id] = 0;
      px_x[id].delete();
      px_y[id].delete();
    end
    if (d) begin
      px_x[id].push_back(m_x[id]);
      px_y[id].push_back(m_y[id]);
    end
    if (l) begin
      m_x[id] = 0;
      if (m_y[id] == ymax[id]) m_err[id] = 1'b1;
      else m_y[id]++;
    end else begin
      if (m_x[id] == xmax[id]) m_err[id] = 1'b1;
      else m_x[id]++;
    end
    if (pub) begin
      r.err = m_err[id];
      r.cyc = at_cyc;
      if (id == 0) q0.push_back(r);
      else q1.push_back(r);
    end
  endtask

  task automatic drive(input int id, input bit v, input bit u, input bit l, input bit d, input bit e);
    @(negedge clk);
    if (id == 0) begin
      v0 = v; u0 = u; l0 = l; d0 = d; en0 = e;
      if (v) chk("tready0", 64'(rdy0), 64'd1);
    end else begin
      v1 = v; u1 = u; l1 = l; d1 = d; en1 = e;
      if (v) chk("tready1", 64'(rdy1), 64'd1);
    end
    model_step(id, v, u, l, d, e, cyc + 1);
  endtask

  task automatic idle(input int id, input int n);
    for (int i = 0; i < n; i++) drive(id, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // mode: 0 diagonal (x==y+1), 1 none, 2 random, 3 single at (2,2), 4 all
  task automatic frame(input int id, input int w, input int h, input int mode, input int gap);
    bit d;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        repeat ($urandom_range(gap, 0)) drive(id, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        case (mode)
          0: d = (x == y + 1);
          1: d = 1'b0;
          2: d = ($urandom_range(3, 0) == 0);
          3: d = (x == 2 && y == 2);
          default: d = 1'b1;
        endcase
        drive(id, 1'b1, (x == 0 && y == 0), (x == w - 1), d, 1'b1);
      end
    end
  endtask

  task automatic sof_flush(input int id);
    drive(id, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(id, 3);
  endtask

  task automatic check_zero_outputs();
    chk("rst_done0", 64'(fd0), 0);  chk("rst_cnt0", 64'(cnt0), 0);
    chk("rst_sx0", 64'(sx0), 0);    chk("rst_sy0", 64'(sy0), 0);
    chk("rst_mnx0", 64'(mnx0), 0);  chk("rst_mxx0", 64'(mxx0), 0);
    chk("rst_mny0", 64'(mny0), 0);  chk("rst_mxy0", 64'(mxy0), 0);
    chk("rst_bv0", 64'(bv0), 0);    chk("rst_err0", 64'(err0), 0);
    chk("rst_rdy0", 64'(rdy0), 0);
    chk("rst_cnt1", 64'(cnt1), 0);  chk("rst_err1", 64'(err1), 0);
    chk("rst_rdy1", 64'(rdy1), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 1'b0;
      m_err[i] = 1'b0;
    end
    @(negedge clk);
    check_zero_outputs();
    rst_n = 1'b1;
  endtask

  task automatic compare(input int id, input res_t e, input longint c, input longint s_x,
                         input longint s_y, input longint a, input longint b, input longint f,
                         input longint g, input bit bv, input bit er);
    string p;
    p = (id == 0) ? "big" : "small";
    chk({p, "_latency"}, 64'(cyc), 64'(e.cyc));
    chk({p, "_count"}, 64'(c), 64'(e.cnt));
    chk({p, "_sum_x"}, 64'(s_x), 64'(e.sx));
    chk({p, "_sum_y"}, 64'(s_y), 64'(e.sy));
    chk({p, "_min_x"}, 64'(a), 64'(e.mnx));
    chk({p, "_max_x"}, 64'(b), 64'(e.mxx));
    chk({p, "_min_y"}, 64'(f), 64'(e.mny));
    chk({p, "_max_y"}, 64'(g), 64'(e.mxy));
    chk({p, "_blob_valid"}, 64'(bv), 64'(e.bv));
    chk({p, "_err_overrun"}, 64'(er), 64'(e.err));
  endtask

  // Monitors: pop one expected result per frame_done pulse.
  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1 && fd0 === 1'b1) begin
      if (q0.size() == 0) chk("big_unexpected_done", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        compare(0, e, longint'(cnt0), longint'(sx0), longint'(sy0), longint'(mnx0),
                longint'(mxx0), longint'(mny0), longint'(mxy0), bv0, err0);
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1 && fd1 === 1'b1) begin
      if (q1.size() == 0) chk("small_unexpected_done", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        compare(1, e, longint'(cnt1), longint'(sx1), longint'(sy1), longint'(mnx1),
                longint'(mxx1), longint'(mny1), longint'(mxy1), bv1, err1);
      end
    end
  end

  initial begin
    xmax[0] = (64'd1 << BX) - 1; ymax[0] = (64'd1 << BY) - 1;
    cmax[0] = (64'd1 << BC) - 1; smax[0] = (64'd1 << BS) - 1;
    xmax[1] = (64'd1 << SX) - 1; ymax[1] = (64'd1 << SY) - 1;
    cmax[1] = (64'd1 << SC) - 1; smax[1] = (64'd1 << SS) - 1;
    rst_n = 1'b0;
    {en0, v0, u0, l0, d0} = 5'b10000;
    {en1, v1, u1, l1, d1} = 5'b10000;
    repeat (2) @(negedge clk);
    apply_reset();
    idle(0, 2);
    idle(1, 2);

    // Diagonal 4x3, empty 4x3, diagonal with gaps
    frame(0, 4, 3, 0, 0);
    frame(0, 4, 3, 1, 0);
    frame(0, 4, 3, 0, 5);
    // Enable drop mid-frame discards the partial frame
    frame(0, 4, 3, 4, 0);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(0, 2);
    frame(0, 4, 3, 3, 0);
    sof_flush(0);
    for (int i = 0; i < 8; i++)
      frame(0, $urandom_range(8, 1), $urandom_range(6, 1), $urandom_range(4, 0), $urandom_range(3, 0));
    sof_flush(0);

    // Reset mid-frame; non-SOF beats afterwards are ignored
    drive(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_reset();
    idle(0, 2);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 1'b0, (i == 1), 1'b1, 1'b1);
    frame(0, 4, 3, 0, 0);
    frame(0, 5, 2, 2, 1);
    sof_flush(0);

    // Small instance: x and y saturation, count/sum saturation, 1-px-wide frames
    idle(1, 2);
    frame(1, 9, 2, 4, 0);
    frame(1, 1, 10, 4, 1);
    frame(1, 1, 1, 4, 0);
    frame(1, 1, 1, 2, 0);
    for (int i = 0; i < 6; i++)
      frame(1, $urandom_range(12, 1), $urandom_range(12, 1), $urandom_range(4, 2), $urandom_range(2, 0));
    sof_flush(1);
    idle(0, 2);

    chk("big_pending", 64'(q0.size()), 64'd0);
    chk("small_pending", 64'(q1.size()), 64'd0);
    chk("big_err_final", 64'(err0), 64'(m_err[0]));
    chk("small_err_final", 64'(err1), 64'(m_err[1]));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
